main_mem_burst_fu: RTL and testbench
====================================

# main_mem_burst_fu

Parametrised multi-channel main-memory transfer unit for the scalar tile. It moves `num_ch` parallel data words per beat between main memory and the local register file, with bursts of up to 2^`burst_width` beats and a programmable address stride. Per-channel request/ack handshakes are independent. It sits in the same slot in the scalar FU as the two-channel single-beat memory port FU and adds four capabilities:

- bursts;
- stride;
- abort and done reporting;
- start re-arm.

## Interface
Parameters:
- `data_width`, 32, width of one main-memory and register-file word.
- `addr_size`, 16, main-memory address width and `config_i` width.
- `num_ch`, 2, number of parallel channels (1..4).
- `reg_set_idx_width`, 3, register-set index width.
- `burst_width`, 3, burst-length field width; the burst length is `L` = field + 1.
- Constraint: `addr_size` ≥ 1 + 2·`reg_set_idx_width` + `burst_width` + 4.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `on_off_i`  in  1  start level; deassertion aborts the current operation.
- `config_i`  in  `addr_size`  operation descriptor, sampled only on start.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse on normal completion.
- `addr_o`  out  `num_ch`·`addr_size`  per-channel main-memory address; channel c occupies slice c.
- `read_en_o`, `write_en_o`  out  `num_ch`  per-channel main-memory requests.
- `read_ack_i`, `write_ack_i`  in  `num_ch`  per-channel main-memory acks.
- `r_data_i`  in  `num_ch`·`data_width`  main-memory read data.
- `w_data_o`  out  `num_ch`·`data_width`  main-memory write data.
- `reg_read_o`, `reg_write_o`  out  `num_ch`  per-channel register-file requests.
- `reg_set_idx_o`  out  `num_ch`·`reg_set_idx_width`  per-channel register-set index.
- `reg_data_o`  out  `num_ch`·`data_width`  data to the register file.
- `reg_data_i`  in  `num_ch`·`data_width`  data from the register file.
- `reg_ack_i`  in  `num_ch`  per-channel register-file acks.

## Operation
- `config_i` fields, LSB first:
  - `op` (1 = read from main memory, 0 = write to main memory);
  - `addr_idx` (`reg_set_idx_width` bits);
  - `data_idx` (`reg_set_idx_width` bits);
  - `blen` (`burst_width` bits);
  - `stride` (4 bits, unsigned);
  - any remaining bits are ignored.
- Start: in IDLE with `on_off_i`=1 and `armed`=1:
  - latch all config fields;
  - clear the beat counter `k` and the per-channel addresses;
  - go to FETCH_ADDR.
- `armed` is cleared on entering DONE and set in any cycle where `on_off_i`=0. A held-high `on_off_i` therefore runs exactly one operation.
- States:
  - IDLE → FETCH_ADDR.
  - FETCH_ADDR → FETCH_WDATA (write) or MEM_ACCESS (read).
  - FETCH_WDATA → MEM_ACCESS.
  - MEM_ACCESS → NEXT (write) or STORE_RDATA (read).
  - STORE_RDATA → NEXT.
  - NEXT: if k = L−1, go to DONE; otherwise k++ and go to FETCH_WDATA or MEM_ACCESS according to `op`. NEXT is resolved combinationally in the same edge and is not a separate cycle.
  - DONE → IDLE.
- Phase rule, for every phase except IDLE/DONE:
  - On entry, all `num_ch` requests of that phase go high.
  - Channel c's request drops the cycle after its ack is sampled, and its `acked[c]` flag is set.
  - The phase exits on the edge at which all flags are set (including acks in that same cycle).
  - Flags clear on exit.
  - An ack with its request low is ignored.
- FETCH_ADDR: channel c reads register set (`addr_idx`+c) mod 2^`reg_set_idx_width` and latches `base[c]` = `reg_data_i` slice c, low `addr_size` bits.
- Data index for beat k, channel c: (`data_idx` + k·`num_ch` + c) mod 2^`reg_set_idx_width`, driven on `reg_set_idx_o`. In FETCH_ADDR, `reg_set_idx_o` carries the address index instead.
- Address for beat k, channel c: (`base[c]` + k·`stride`) mod 2^`addr_size`, truncated with wrap.
- FETCH_WDATA latches `reg_data_i` slice c into `w_data_o` slice c on that channel's ack.
- MEM_ACCESS latches `r_data_i` on a read ack; `w_data_o` and `addr_o` are held stable while `write_en_o` is high.
- STORE_RDATA drives the latched read data on `reg_data_o`.
- Abort: `on_off_i`=0 in any non-IDLE state. All requests go low combinationally in that cycle, the next state is IDLE, and `done_o` is not pulsed. Abort takes priority over phase completion in the same cycle.
- Outputs not owned by the current phase are 0, except `addr_o` and `w_data_o`, which hold their registered values.

## Timing
- Reset (`reset_ni`=0, asynchronous) clears everything:
  - outputs: `busy_o`, `done_o`, all enables and requests, `addr_o`, `w_data_o`, `reg_data_o` and `reg_set_idx_o` all 0;
  - internal state: IDLE, `armed`=1, all internal registers 0.
- Reset release is taken on the next clock edge.
- Zero-wait latency (every ack in the first request cycle), with start sampled at cycle 0: FETCH_ADDR at cycle 1, first phase of beat 0 at cycle 2, `done_o` at cycle 2+2L. This holds for both read and write.
- Each extra wait cycle on the slowest channel of a phase adds exactly one cycle.
- Requests are registered-state outputs, valid from the first cycle of their phase.

## Test plan
- Read, `num_ch`=2, L=1, stride 0, register sets 1/2 holding 0x0010/0x0020, all acks immediate → `read_en_o`=2'b11 at cycle 2 with addresses 0x0010/0x0020; read data written to `data_idx`/`data_idx`+1 at cycle 3; `done_o` at cycle 4 only.
- Write, L=4, stride 2, base 0x0100 → channel-0 addresses 0x0100, 0x0102, 0x0104, 0x0106; register indices advance by `num_ch` per beat; `done_o` at cycle 10.
- Skewed acks: channel 0 acks at cycle +0, channel 1 at cycle +3 → `read_en_o[0]` drops after one cycle, `read_en_o[1]` stays high for four cycles; the phase exits once, and both data words are correct.
- Wrap: base 0xFFFE, stride 4, L=2 → beat-1 address 0x0002; data index 7 with `data_idx`=6, c=1; next index wraps to 0.
- Abort: drop `on_off_i` at beat 2 of L=4 → all requests are 0 in the same cycle; IDLE next cycle; no `done_o`; raising `on_off_i` again restarts from beat 0.
- Re-arm and reset: holding `on_off_i`=1 after `done_o` → remains in IDLE. Asserting `reset_ni`=0 mid-MEM_ACCESS → outputs clear without a clock edge.

Source files
------------

// File: rtl/main_mem_burst_fu.sv
// Multi-channel burst transfer unit that moves data between main memory and the register file.
// Each beat moves num_ch words. A burst has blen+1 beats, and the address advances by stride
// on every beat. Every phase has one independent request/ack handshake per channel.
module main_mem_burst_fu #(
    parameter int unsigned data_width        = 32,
    parameter int unsigned addr_size         = 16,
    parameter int unsigned num_ch            = 2,
    parameter int unsigned reg_set_idx_width = 3,
    parameter int unsigned burst_width       = 3
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                on_off_i,
    input  logic [addr_size-1:0]                config_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [num_ch*addr_size-1:0]         addr_o,
    output logic [num_ch-1:0]                   read_en_o,
    output logic [num_ch-1:0]                   write_en_o,
    input  logic [num_ch-1:0]                   read_ack_i,
    input  logic [num_ch-1:0]                   write_ack_i,
    input  logic [num_ch*data_width-1:0]        r_data_i,
    output logic [num_ch*data_width-1:0]        w_data_o,
    output logic [num_ch-1:0]                   reg_read_o,
    output logic [num_ch-1:0]                   reg_write_o,
    output logic [num_ch*reg_set_idx_width-1:0] reg_set_idx_o,
    output logic [num_ch*data_width-1:0]        reg_data_o,
    input  logic [num_ch*data_width-1:0]        reg_data_i,
    input  logic [num_ch-1:0]                   reg_ack_i
);
    localparam int unsigned IW = reg_set_idx_width;
    localparam int unsigned BW = burst_width;
    localparam int unsigned AW = addr_size;
    localparam int unsigned DW = data_width;
    localparam int unsigned AddrIdxLsb = 1;
    localparam int unsigned DataIdxLsb = 1 + IW;
    localparam int unsigned BlenLsb    = 1 + 2 * IW;
    localparam int unsigned StrideLsb  = 1 + 2 * IW + BW;

    typedef enum logic [2:0] {
        StIdle, StFetchAddr, StFetchWdata, StMemAccess, StStoreRdata, StDone
    } state_e;

    state_e state_q, state_d;
    logic                        armed_q, armed_d;
    logic                        op_q, op_d;
    logic [IW-1:0]               addr_idx_q, addr_idx_d;
    logic [IW-1:0]               data_idx_q, data_idx_d;
    logic [BW-1:0]               blen_q, blen_d;
    logic [3:0]                  stride_q, stride_d;
    logic [BW-1:0]               k_q, k_d;
    logic [num_ch-1:0]           req_q, req_d;
    logic [num_ch-1:0]           acked_q, acked_d;
    logic [num_ch-1:0][AW-1:0]   addr_q, addr_d;
    logic [num_ch-1:0][DW-1:0]   w_data_q, w_data_d;
    logic [num_ch-1:0][DW-1:0]   r_data_q, r_data_d;

    logic              start, abort, phase_done, last_beat, advance;
    logic [num_ch-1:0] phase_ack, ack_hit, req_out;
    logic              unused_cfg;

    // Bits of config_i above the stride field carry no meaning.
    assign unused_cfg = ^config_i;

    assign start      = (state_q == StIdle) && on_off_i && armed_q;
    assign abort      = (state_q != StIdle) && !on_off_i;
    assign ack_hit    = req_q & phase_ack;
    assign phase_done = &(acked_q | ack_hit);
    assign last_beat  = (k_q == blen_q);
    // A beat ends on the last phase of that beat. The NEXT step is folded into this edge.
    assign advance    = !abort && phase_done && !last_beat &&
                        ((state_q == StMemAccess && !op_q) || state_q == StStoreRdata);

    // Select the ack bus that belongs to the current phase.
    always_comb begin
        phase_ack = '0;
        unique case (state_q)
            StFetchAddr, StFetchWdata, StStoreRdata: phase_ack = reg_ack_i;
            StMemAccess: phase_ack = op_q ? read_ack_i : write_ack_i;
            default:     phase_ack = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= StIdle;
        else           state_q <= state_d;
    end

    // Next-state logic. Abort overrides phase completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:       if (start) state_d = StFetchAddr;
            StFetchAddr:  if (phase_done) state_d = op_q ? StMemAccess : StFetchWdata;
            StFetchWdata: if (phase_done) state_d = StMemAccess;
            StMemAccess: begin
                if (phase_done) begin
                    if (op_q)           state_d = StStoreRdata;
                    else if (last_beat) state_d = StDone;
                    else                state_d = StFetchWdata;
                end
            end
            StStoreRdata: if (phase_done) state_d = last_beat ? StDone : StMemAccess;
            StDone:       state_d = StIdle;
            default:      state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Datapath next-state: config latch, beat counter, addresses, data and handshake flags.
    always_comb begin
        armed_d    = armed_q;
        op_d       = op_q;
        addr_idx_d = addr_idx_q;
        data_idx_d = data_idx_q;
        blen_d     = blen_q;
        stride_d   = stride_q;
        k_d        = k_q;
        addr_d     = addr_q;
        w_data_d   = w_data_q;
        r_data_d   = r_data_q;
        if (start) begin
            op_d       = config_i[0];
            addr_idx_d = config_i[AddrIdxLsb +: IW];
            data_idx_d = config_i[DataIdxLsb +: IW];
            blen_d     = config_i[BlenLsb +: BW];
            stride_d   = config_i[StrideLsb +: 4];
            k_d        = '0;
            addr_d     = '0;
        end
        for (int c = 0; c < num_ch; c++) begin
            if (ack_hit[c]) begin
                if (state_q == StFetchAddr)          addr_d[c]   = reg_data_i[c*DW +: AW];
                if (state_q == StFetchWdata)         w_data_d[c] = reg_data_i[c*DW +: DW];
                if (state_q == StMemAccess && op_q)  r_data_d[c] = r_data_i[c*DW +: DW];
            end
        end
        if (advance) begin
            k_d = k_q + 1'b1;
            for (int c = 0; c < num_ch; c++) addr_d[c] = addr_q[c] + AW'(stride_q);
        end
        if (state_d != state_q) begin
            acked_d = '0;
            req_d   = (state_d inside {StFetchAddr, StFetchWdata, StMemAccess, StStoreRdata})
                      ? '1 : '0;
        end else begin
            acked_d = acked_q | ack_hit;
            req_d   = req_q & ~ack_hit;
        end
        // Re-arm needs on_off_i low for at least one cycle after each completion.
        if (!on_off_i)                                armed_d = 1'b1;
        else if (state_d == StDone && state_q != StDone) armed_d = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            armed_q    <= 1'b1;
            op_q       <= 1'b0;
            addr_idx_q <= '0;
            data_idx_q <= '0;
            blen_q     <= '0;
            stride_q   <= '0;
            k_q        <= '0;
            req_q      <= '0;
            acked_q    <= '0;
            addr_q     <= '0;
            w_data_q   <= '0;
            r_data_q   <= '0;
        end else begin
            armed_q    <= armed_d;
            op_q       <= op_d;
            addr_idx_q <= addr_idx_d;
            data_idx_q <= data_idx_d;
            blen_q     <= blen_d;
            stride_q   <= stride_d;
            k_q        <= k_d;
            req_q      <= req_d;
            acked_q    <= acked_d;
            addr_q     <= addr_d;
            w_data_q   <= w_data_d;
            r_data_q   <= r_data_d;
        end
    end

    // Outputs. Only the phase that owns an output drives it. Abort masks requests immediately.
    always_comb begin
        req_out       = abort ? '0 : req_q;
        busy_o        = (state_q != StIdle);
        done_o        = (state_q == StDone);
        addr_o        = addr_q;
        w_data_o      = w_data_q;
        reg_read_o    = '0;
        reg_write_o   = '0;
        read_en_o     = '0;
        write_en_o    = '0;
        reg_data_o    = '0;
        reg_set_idx_o = '0;
        unique case (state_q)
            StFetchAddr:  reg_read_o  = req_out;
            StFetchWdata: reg_read_o  = req_out;
            StMemAccess: begin
                if (op_q) read_en_o  = req_out;
                else      write_en_o = req_out;
            end
            StStoreRdata: begin
                reg_write_o = req_out;
                reg_data_o  = r_data_q;
            end
            default: ;
        endcase
        for (int c = 0; c < num_ch; c++) begin
            if (state_q == StFetchAddr) begin
                reg_set_idx_o[c*IW +: IW] = addr_idx_q + IW'(c);
            end else if (state_q == StFetchWdata || state_q == StStoreRdata) begin
                reg_set_idx_o[c*IW +: IW] =
                    data_idx_q + IW'(int'(k_q) * int'(num_ch) + c);
            end
        end
    end
endmodule

// File: tb/tb_main_mem_burst_fu.sv
// Directed bench for main_mem_burst_fu with the default parameters (2 channels, 16-bit addresses).
// The memory returns {16'hA5A5, address} for each channel. The register file is a small array.
module tb_main_mem_burst_fu;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned NC = 2;
    localparam int unsigned IW = 3;

    logic                 clk_i = 1'b0;
    logic                 reset_ni;
    logic                 on_off_i;
    logic [AW-1:0]        config_i;
    logic                 busy_o, done_o;
    logic [NC*AW-1:0]     addr_o;
    logic [NC-1:0]        read_en_o, write_en_o, read_ack_i, write_ack_i;
    logic [NC*DW-1:0]     r_data_i, w_data_o, reg_data_o, reg_data_i;
    logic [NC-1:0]        reg_read_o, reg_write_o, reg_ack_i;
    logic [NC*IW-1:0]     reg_set_idx_o;
    logic [NC-1:0]        ack_en;
    logic [31:0]          regs [8];
    int                   tests_run = 0;
    int                   tests_failed = 0;
    logic [2:0]           i0, i1;
    logic [15:0]          a0, a1;

    always #5 clk_i = ~clk_i;

    assign reg_ack_i   = (reg_read_o | reg_write_o) & ack_en;
    assign read_ack_i  = read_en_o & ack_en;
    assign write_ack_i = write_en_o & ack_en;
    assign r_data_i    = {16'hA5A5, addr_o[31:16], 16'hA5A5, addr_o[15:0]};
    assign reg_data_i  = {regs[reg_set_idx_o[5:3]], regs[reg_set_idx_o[2:0]]};

    main_mem_burst_fu dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .on_off_i     (on_off_i),
        .config_i     (config_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .addr_o       (addr_o),
        .read_en_o    (read_en_o),
        .write_en_o   (write_en_o),
        .read_ack_i   (read_ack_i),
        .write_ack_i  (write_ack_i),
        .r_data_i     (r_data_i),
        .w_data_o     (w_data_o),
        .reg_read_o   (reg_read_o),
        .reg_write_o  (reg_write_o),
        .reg_set_idx_o(reg_set_idx_o),
        .reg_data_o   (reg_data_o),
        .reg_data_i   (reg_data_i),
        .reg_ack_i    (reg_ack_i)
    );

    function automatic logic [15:0] cfg(input logic op, input logic [2:0] ai, input logic [2:0] di,
                                        input logic [2:0] bl, input logic [3:0] st);
        return {2'b00, st, bl, di, ai, op};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_ni = 1'b0;
        on_off_i = 1'b0;
        config_i = '0;
        ack_en   = 2'b11;
        for (int i = 0; i < 8; i++) regs[i] = 32'hD000_0000 | 32'(i);
        regs[1] = 32'h0000_0010;
        regs[2] = 32'h0000_0020;
        regs[3] = 32'h0000_0100;
        regs[4] = 32'h0000_0200;
        regs[5] = 32'h0000_FFFE;
        regs[6] = 32'h0000_1234;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", w_data_o, 0);
        check("rst_en", {read_en_o, write_en_o, reg_read_o, reg_write_o}, 0);
        check("rst_idx", reg_set_idx_o, 0);
        step();
        step();
        reset_ni = 1'b1;
        step();

        // Read, L=1, stride 0, address sets 1/2.
        config_i = cfg(1'b1, 3'd1, 3'd4, 3'd0, 4'd0);
        on_off_i = 1'b1;
        #1;
        check("rd_c0_busy", busy_o, 0);
        step();
        check("rd_c1_busy", busy_o, 1);
        check("rd_c1_regrd", reg_read_o, 2'b11);
        check("rd_c1_idx", reg_set_idx_o, {3'd2, 3'd1});
        step();
        check("rd_c2_rden", read_en_o, 2'b11);
        check("rd_c2_addr", addr_o, {16'h0020, 16'h0010});
        check("rd_c2_regrd", reg_read_o, 2'b00);
        step();
        check("rd_c3_regwr", reg_write_o, 2'b11);
        check("rd_c3_idx", reg_set_idx_o, {3'd5, 3'd4});
        check("rd_c3_data", reg_data_o, {32'hA5A5_0020, 32'hA5A5_0010});
        check("rd_c3_done", done_o, 0);
        step();
        check("rd_c4_done", done_o, 1);
        check("rd_c4_regwr", reg_write_o, 2'b00);
        step();
        check("rd_c5_done", done_o, 0);
        check("rd_c5_busy", busy_o, 0);
        step();
        check("rearm_hold_busy", busy_o, 0);
        on_off_i = 1'b0;
        step();

        // Write, L=4, stride 2, base 0x0100 / 0x0200.
        config_i = cfg(1'b0, 3'd3, 3'd0, 3'd3, 4'd2);
        on_off_i = 1'b1;
        step();
        check("wr_c1_idx", reg_set_idx_o, {3'd4, 3'd3});
        for (int b = 0; b < 4; b++) begin
            i0 = 3'(2 * b);
            i1 = 3'(2 * b + 1);
            a0 = 16'h0100 + 16'(2 * b);
            a1 = 16'h0200 + 16'(2 * b);
            step();
            check("wr_fw_regrd", reg_read_o, 2'b11);
            check("wr_fw_idx", reg_set_idx_o, {i1, i0});
            check("wr_fw_done", done_o, 0);
            step();
            check("wr_mem_wren", write_en_o, 2'b11);
            check("wr_mem_addr", addr_o, {a1, a0});
            check("wr_mem_wdata", w_data_o, {regs[i1], regs[i0]});
        end
        step();
        check("wr_c10_done", done_o, 1);
        step();
        check("wr_c11_busy", busy_o, 0);
        on_off_i = 1'b0;
        step();

        // Skewed acks: channel 1 acks three cycles after channel 0.
        config_i = cfg(1'b1, 3'd1, 3'd2, 3'd0, 4'd0);
        on_off_i = 1'b1;
        step();
        step();
        ack_en = 2'b01;
        #1;
        check("skew_c2_rden", read_en_o, 2'b11);
        step();
        check("skew_c3_rden", read_en_o, 2'b10);
        step();
        check("skew_c4_rden", read_en_o, 2'b10);
        step();
        ack_en = 2'b11;
        #1;
        check("skew_c5_rden", read_en_o, 2'b10);
        step();
        check("skew_c6_rden", read_en_o, 2'b00);
        check("skew_c6_regwr", reg_write_o, 2'b11);
        check("skew_c6_idx", reg_set_idx_o, {3'd3, 3'd2});
        check("skew_c6_data", reg_data_o, {32'hA5A5_0020, 32'hA5A5_0010});
        step();
        check("skew_c7_done", done_o, 1);
        step();
        check("skew_c8_done", done_o, 0);
        on_off_i = 1'b0;
        step();

        // Address and index wrap: base 0xFFFE, stride 4, L=2, data_idx 6.
        config_i = cfg(1'b1, 3'd5, 3'd6, 3'd1, 4'd4);
        on_off_i = 1'b1;
        step();
        check("wrap_c1_idx", reg_set_idx_o, {3'd6, 3'd5});
        step();
        check("wrap_c2_addr", addr_o, {16'h1234, 16'hFFFE});
        step();
        check("wrap_c3_idx", reg_set_idx_o, {3'd7, 3'd6});
        check("wrap_c3_data", reg_data_o, {32'hA5A5_1234, 32'hA5A5_FFFE});
        step();
        check("wrap_c4_addr", addr_o, {16'h1238, 16'h0002});
        step();
        check("wrap_c5_idx", reg_set_idx_o, {3'd1, 3'd0});
        check("wrap_c5_data", reg_data_o, {32'hA5A5_1238, 32'hA5A5_0002});
        step();
        check("wrap_c6_done", done_o, 1);
        on_off_i = 1'b0;
        step();

        // Abort during the beat-2 memory access of a 4-beat write.
        config_i = cfg(1'b0, 3'd3, 3'd0, 3'd3, 4'd1);
        on_off_i = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("abort_c7_wren", write_en_o, 2'b11);
        check("abort_c7_addr", addr_o, {16'h0202, 16'h0102});
        on_off_i = 1'b0;
        #1;
        check("abort_comb_wren", write_en_o, 2'b00);
        check("abort_comb_done", done_o, 0);
        step();
        check("abort_idle_busy", busy_o, 0);
        check("abort_idle_done", done_o, 0);
        step();
        check("abort_idle2_done", done_o, 0);
        on_off_i = 1'b1;
        step();
        check("restart_c1_regrd", reg_read_o, 2'b11);
        step();
        check("restart_c2_idx", reg_set_idx_o, {3'd1, 3'd0});
        step();
        check("restart_c3_addr", addr_o, {16'h0200, 16'h0100});
        check("restart_c3_wren", write_en_o, 2'b11);

        // Asynchronous reset in the middle of a memory access.
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_rst_wren", write_en_o, 2'b00);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_addr", addr_o, 0);
        check("async_rst_wdata", w_data_o, 0);
        check("async_rst_idx", reg_set_idx_o, 0);
        on_off_i = 1'b0;
        step();
        reset_ni = 1'b1;
        step();
        check("post_rst_busy", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
